// File: rtl/thermo_pkg.sv
// Shared types and constants for the digital thermometer.
//   thermo_class_e : displayed/candidate temperature class (2 bits)
//   GLYPH_*        : 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   DEF_*          : default thresholds and filter depth
package thermo_pkg;

    localparam int unsigned TEMP_W         = 8;
    localparam int unsigned SEG_W          = 7;
    localparam int unsigned DEF_COLD_TH    = 20;
    localparam int unsigned DEF_HOT_TH     = 40;
    localparam int unsigned DEF_STABLE_CNT = 2;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_COLD   = 2'd1,
        CLS_NORMAL = 2'd2,
        CLS_HOT    = 2'd3
    } thermo_class_e;

    localparam logic [SEG_W-1:0] GLYPH_NONE   = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_COLD   = 7'b0111001;  // "C"
    localparam logic [SEG_W-1:0] GLYPH_NORMAL = 7'b1010100;  // "n"
    localparam logic [SEG_W-1:0] GLYPH_HOT    = 7'b1110110;  // "H"

    // Both thresholds are inclusive in the NORMAL band.
    function automatic thermo_class_e classify_temp(
        input logic [TEMP_W-1:0] t,
        input logic [TEMP_W-1:0] cold_th,
        input logic [TEMP_W-1:0] hot_th
    );
        if (t < cold_th) begin
            return CLS_COLD;
        end
        if (t > hot_th) begin
            return CLS_HOT;
        end
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/thermo_seg_enc.sv
// Combinational class -> 7-segment glyph encoder.
//   cls     : temperature class
//   glyph_c : segment pattern {g,f,e,d,c,b,a}, active-high
module thermo_seg_enc
    import thermo_pkg::*;
(
    input  thermo_class_e    cls,
    output logic [SEG_W-1:0] glyph_c
);

    always_comb begin
        glyph_c = GLYPH_NONE;
        case (cls)
            CLS_COLD:   glyph_c = GLYPH_COLD;
            CLS_NORMAL: glyph_c = GLYPH_NORMAL;
            CLS_HOT:    glyph_c = GLYPH_HOT;
            CLS_NONE:   glyph_c = GLYPH_NONE;
        endcase
    end

endmodule

// File: rtl/digital_thermometer.sv
// Temperature classifier with flicker filter and front-panel drive.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   temp   : unsigned temperature in degrees C
//   seg    : registered 7-segment glyph {g,f,e,d,c,b,a}
//   hot    : registered, displayed class is HOT
//   normal : registered, displayed class is NORMAL
//   cold   : registered, displayed class is COLD
module digital_thermometer
    import thermo_pkg::*;
#(
    parameter int unsigned COLD_TH    = DEF_COLD_TH,
    parameter int unsigned HOT_TH     = DEF_HOT_TH,
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temp,
    output logic [SEG_W-1:0]  seg,
    output logic              hot,
    output logic              normal,
    output logic              cold
);

    localparam int unsigned       CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [TEMP_W-1:0] COLD_T  = TEMP_W'(COLD_TH);
    localparam logic [TEMP_W-1:0] HOT_T   = TEMP_W'(HOT_TH);

    logic [TEMP_W-1:0] temp_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    thermo_class_e     cand;
    thermo_class_e     pend;
    thermo_class_e     pend_n;
    thermo_class_e     disp;
    thermo_class_e     disp_n;
    logic [SEG_W-1:0]  glyph_c;

    // Classification of the sampled temperature.
    always_comb begin
        cand = classify_temp(temp_q, COLD_T, HOT_T);
    end

    // Stability filter next state. Outputs are registered from disp_n so the
    // panel changes on the same edge the displayed class does.
    always_comb begin
        pend_n = pend;
        cnt_n  = cnt;
        disp_n = disp;
        if (cand == disp) begin
            cnt_n  = '0;
            pend_n = cand;
        end else if (cand == pend) begin
            if (cnt != CNT_MAX) begin
                cnt_n = cnt + CNT_W'(1);
            end
        end else begin
            pend_n = cand;
            cnt_n  = CNT_W'(1);
        end
        if (cnt_n == CNT_MAX) begin
            disp_n = pend_n;
            cnt_n  = '0;
        end
    end

    thermo_seg_enc u_seg_enc (
        .cls     (disp_n),
        .glyph_c (glyph_c)
    );

    // Sample register, filter state and registered panel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_q <= '0;
            cnt    <= '0;
            pend   <= CLS_NONE;
            disp   <= CLS_NONE;
            seg    <= GLYPH_NONE;
            hot    <= 1'b0;
            normal <= 1'b0;
            cold   <= 1'b0;
        end else begin
            temp_q <= temp;
            cnt    <= cnt_n;
            pend   <= pend_n;
            disp   <= disp_n;
            seg    <= glyph_c;
            hot    <= (disp_n == CLS_HOT);
            normal <= (disp_n == CLS_NORMAL);
            cold   <= (disp_n == CLS_COLD);
        end
    end

endmodule

// File: tb/tb_digital_thermometer.sv
// Self-checking bench for digital_thermometer: directed table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_digital_thermometer;
    import thermo_pkg::*;

    localparam int unsigned COLD_TH = 20;
    localparam int unsigned HOT_TH  = 40;
    localparam int unsigned NSTAB   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] temp;
    logic [6:0] seg;
    logic       hot;
    logic       normal;
    logic       cold;

    int errors = 0;
    int checks = 0;

    // Reference model: the displayed class switches to X once the last NSTAB
    // classified samples are all X and X differs from what is shown.
    int unsigned   m_tq;
    thermo_class_e m_disp;
    thermo_class_e m_hist[$];

    typedef struct {
        logic [7:0]    t;
        thermo_class_e prev;
        thermo_class_e next;
    } vec_t;

    vec_t vecs[9];

    digital_thermometer #(
        .COLD_TH    (COLD_TH),
        .HOT_TH     (HOT_TH),
        .STABLE_CNT (NSTAB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .temp   (temp),
        .seg    (seg),
        .hot    (hot),
        .normal (normal),
        .cold   (cold)
    );

    always #5 clk = ~clk;

    function automatic thermo_class_e ref_class(input int unsigned t);
        if (t < COLD_TH) return CLS_COLD;
        if (t > HOT_TH)  return CLS_HOT;
        return CLS_NORMAL;
    endfunction

    // Expected {seg, hot, normal, cold}.
    function automatic logic [9:0] expect_bits(input thermo_class_e c);
        case (c)
            CLS_COLD:   return {7'b0111001, 3'b001};
            CLS_NORMAL: return {7'b1010100, 3'b010};
            CLS_HOT:    return {7'b1110110, 3'b100};
            default:    return {7'b0000000, 3'b000};
        endcase
    endfunction

    task automatic model_reset();
        m_tq   = 0;
        m_disp = CLS_NONE;
        m_hist.delete();
    endtask

    task automatic model_edge(input int unsigned t);
        thermo_class_e c;
        bit            same;
        c = ref_class(m_tq);
        m_hist.push_back(c);
        if (m_hist.size() > NSTAB) void'(m_hist.pop_front());
        m_tq = t;
        if (m_hist.size() == NSTAB) begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != c) same = 1'b0;
            if (same && c != m_disp) m_disp = c;
        end
    endtask

    task automatic check(input string name, input thermo_class_e exp);
        logic [9:0] got;
        logic [9:0] want;
        got  = {seg, hot, normal, cold};
        want = expect_bits(exp);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got seg=%b hot=%b normal=%b cold=%b, want seg=%b flags(h,n,c)=%b",
                     name, seg, hot, normal, cold, want[9:3], want[2:0]);
        end
    endtask

    // Called at a negedge: drive temp, take one rising edge, return at negedge.
    task automatic step(input logic [7:0] t);
        temp = t;
        @(posedge clk);
        model_edge(int'(t));
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'd10,  CLS_NORMAL, CLS_COLD};
        vecs[1] = '{8'd30,  CLS_COLD,   CLS_NORMAL};
        vecs[2] = '{8'd55,  CLS_NORMAL, CLS_HOT};
        vecs[3] = '{8'd20,  CLS_HOT,    CLS_NORMAL};
        vecs[4] = '{8'd19,  CLS_NORMAL, CLS_COLD};
        vecs[5] = '{8'd40,  CLS_COLD,   CLS_NORMAL};
        vecs[6] = '{8'd41,  CLS_NORMAL, CLS_HOT};
        vecs[7] = '{8'd0,   CLS_HOT,    CLS_COLD};
        vecs[8] = '{8'd255, CLS_COLD,   CLS_HOT};

        // Reset held for two cycles.
        rst  = 1'b1;
        temp = 8'd0;
        model_reset();
        @(negedge clk);
        check("reset_c1", CLS_NONE);
        @(negedge clk);
        check("reset_c2", CLS_NONE);

        // First class after reset: the cleared sample counts as a COLD vote
        // on the first edge, so NORMAL still needs three edges.
        temp = 8'd30;
        rst  = 1'b0;
        step(8'd30);
        check("init_e1", CLS_NONE);
        step(8'd30);
        check("init_e2", CLS_NONE);
        step(8'd30);
        check("init_e3", CLS_NORMAL);
        step(8'd30);

        // Table: each held value changes the display on exactly the 3rd edge.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].t);
            check($sformatf("vec%0d_e1", i), vecs[i].prev);
            step(vecs[i].t);
            check($sformatf("vec%0d_e2", i), vecs[i].prev);
            step(vecs[i].t);
            check($sformatf("vec%0d_e3", i), vecs[i].next);
            step(vecs[i].t);
            check($sformatf("vec%0d_e4", i), vecs[i].next);
        end

        // One-cycle excursion to HOT never reaches the panel.
        repeat (4) step(8'd30);
        check("glitch_pre", CLS_NORMAL);
        step(8'd55);
        check("glitch_spike", CLS_NORMAL);
        for (int i = 0; i < 4; i++) begin
            step(8'd30);
            check($sformatf("glitch_after%0d", i), CLS_NORMAL);
        end

        // Asynchronous reset between edges while HOT is displayed.
        repeat (4) step(8'd55);
        check("arst_pre", CLS_HOT);
        #2;
        rst = 1'b1;
        #1;
        check("arst_immediate", CLS_NONE);
        model_reset();
        @(negedge clk);
        check("arst_held", CLS_NONE);
        temp = 8'd55;
        rst  = 1'b0;
        step(8'd55);
        check("arst_rel_e1", CLS_NONE);
        step(8'd55);
        check("arst_rel_e2", CLS_NONE);
        step(8'd55);
        check("arst_rel_e3", CLS_HOT);

        // Randomized runs, biased around both thresholds.
        for (int n = 0; n < 120; n++) begin
            int unsigned mode;
            int unsigned len;
            logic [7:0]  t;
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 4);
            case (mode)
                0:       t = 8'($urandom_range(0, 255));
                1:       t = 8'($urandom_range(COLD_TH - 3, COLD_TH + 3));
                default: t = 8'($urandom_range(HOT_TH - 3, HOT_TH + 3));
            endcase
            for (int k = 0; k < int'(len); k++) begin
                step(t);
                check($sformatf("rand%0d_%0d_t%0d", n, k, t), m_disp);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
